// File: rtl/johnson_ring_ctrl.sv
// johnson_ring_ctrl
// Controller for an N-bit twisted-ring (Johnson) counter. It owns the ring
// register and tracks the phase index alongside it. It supports run/stop,
// a single-step handshake in HOLD, direction control, seed load with a
// legality check, and a wrap counter. An illegal seed raises a sticky err
// and forces a one-cycle FAULT state, after which the block returns to IDLE.
module johnson_ring_ctrl #(
    parameter int  N     = 6,
    parameter int  WRAPW = 8,
    localparam int PW    = $clog2(2*N)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             dir,
    input  logic             step_req,
    output logic             step_ack,
    input  logic             seed_valid,
    input  logic [N-1:0]     seed,
    input  logic             clr_err,
    output logic [N-1:0]     q,
    output logic [PW-1:0]    phase,
    output logic [WRAPW-1:0] wraps,
    output logic             busy,
    output logic             err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        HOLD  = 2'd2,
        FAULT = 2'd3
    } state_t;

    localparam logic [PW-1:0] LAST_PHASE = PW'(2*N-1);

    state_t           state_q, state_d;
    logic [N-1:0]     ring_q, ring_d;
    logic [PW-1:0]    phase_q, phase_d;
    logic [WRAPW-1:0] wraps_q, wraps_d;
    logic             step_ack_q, step_ack_d;
    logic             err_q, err_d;

    // Seed decode results
    int unsigned      seed_ones;
    logic [N-1:0]     seed_mask;
    logic             seed_legal;
    logic [PW-1:0]    seed_phase;

    // One-shift lookahead in the direction currently requested
    logic [N-1:0]     shift_ring;
    logic [PW-1:0]    shift_phase;
    logic             shift_wrap;

    logic             do_shift;
    logic             do_load;

    // Seed legality and phase: a legal pattern is fully determined by its
    // popcount and its MSB, so rebuild that pattern and compare it to the seed.
    always_comb begin
        seed_ones = 0;
        for (int unsigned i = 0; i < N; i++) begin
            if (seed[i]) begin
                seed_ones = seed_ones + 1;
            end
        end
        if (seed[N-1] || (seed == '0)) begin
            seed_mask  = {N{1'b1}} << (N - seed_ones);
            seed_phase = PW'(seed_ones);
        end else begin
            seed_mask  = {N{1'b1}} >> (N - seed_ones);
            seed_phase = PW'(2*N - seed_ones);
        end
        seed_legal = (seed == seed_mask);
    end

    // Next ring value, phase, and wrap flag for a single shift in direction dir
    always_comb begin
        if (!dir) begin
            shift_ring  = {~ring_q[0], ring_q[N-1:1]};
            shift_wrap  = (phase_q == LAST_PHASE);
            shift_phase = shift_wrap ? '0 : phase_q + PW'(1);
        end else begin
            shift_ring  = {ring_q[N-2:0], ~ring_q[N-1]};
            shift_wrap  = (phase_q == '0);
            shift_phase = shift_wrap ? LAST_PHASE : phase_q - PW'(1);
        end
    end

    // Next-state and datapath selection: seed_valid > stop > start > step_req
    always_comb begin
        state_d    = state_q;
        ring_d     = ring_q;
        phase_d    = phase_q;
        wraps_d    = wraps_q;
        step_ack_d = 1'b0;
        err_d      = err_q & ~clr_err;
        do_shift   = 1'b0;
        do_load    = 1'b0;

        case (state_q)
            IDLE: begin
                if (seed_valid) begin
                    do_load = 1'b1;
                end else if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = HOLD;
                end else begin
                    do_shift = 1'b1;
                end
            end
            HOLD: begin
                if (seed_valid) begin
                    do_load = 1'b1;
                end else if (stop) begin
                    state_d = IDLE;
                end else if (start) begin
                    state_d = RUN;
                end else if (step_req && !step_ack_q) begin
                    do_shift   = 1'b1;
                    step_ack_d = 1'b1;
                end
            end
            FAULT: begin
                state_d = IDLE;
                ring_d  = '0;
                phase_d = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (do_shift) begin
            ring_d  = shift_ring;
            phase_d = shift_phase;
            if (shift_wrap) begin
                wraps_d = wraps_q + WRAPW'(1);
            end
        end

        // An illegal seed overrides a same-edge clr_err
        if (do_load) begin
            if (seed_legal) begin
                ring_d  = seed;
                phase_d = seed_phase;
            end else begin
                ring_d  = '0;
                phase_d = '0;
                err_d   = 1'b1;
                state_d = FAULT;
            end
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            ring_q     <= '0;
            phase_q    <= '0;
            wraps_q    <= '0;
            step_ack_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ring_q     <= ring_d;
            phase_q    <= phase_d;
            wraps_q    <= wraps_d;
            step_ack_q <= step_ack_d;
            err_q      <= err_d;
        end
    end

    assign q        = ring_q;
    assign phase    = phase_q;
    assign wraps    = wraps_q;
    assign step_ack = step_ack_q;
    assign err      = err_q;
    assign busy     = (state_q == RUN);

endmodule

// File: tb/tb_johnson_ring_ctrl.sv
// Scoreboard bench for johnson_ring_ctrl: a behavioural model predicts the
// outputs of each edge, queues them, and compares them after that edge.
module tb_johnson_ring_ctrl;
    localparam int N     = 6;
    localparam int WRAPW = 8;
    localparam int PW    = 4;

    logic             clk = 1'b0;
    logic             reset, start, stop, dir, step_req, seed_valid, clr_err;
    logic [N-1:0]     seed;
    logic             step_ack, busy, err;
    logic [N-1:0]     q;
    logic [PW-1:0]    phase;
    logic [WRAPW-1:0] wraps;

    johnson_ring_ctrl #(.N(N), .WRAPW(WRAPW)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .dir(dir),
        .step_req(step_req), .step_ack(step_ack), .seed_valid(seed_valid),
        .seed(seed), .clr_err(clr_err), .q(q), .phase(phase), .wraps(wraps),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string            name;
        logic [N-1:0]     q;
        logic [PW-1:0]    phase;
        logic [WRAPW-1:0] wraps;
        logic             busy;
        logic             err;
        logic             ack;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    typedef enum {M_IDLE, M_RUN, M_HOLD, M_FAULT} mst_t;
    mst_t m_st    = M_IDLE;
    int   m_phase = 0;
    int   m_wraps = 0;
    logic m_err   = 1'b0;
    logic m_ack   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Ring pattern for a given forward-sequence index
    function automatic logic [N-1:0] pat(input int p);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) begin
            r[i] = (p <= N) ? (i >= N - p) : (i < 2*N - p);
        end
        return r;
    endfunction

    // Apply one edge of stimulus, predict, queue, then compare after the edge
    task automatic cyc(input string name, input logic rst, input logic st, input logic sp,
                       input logic d, input logic req, input logic sv,
                       input logic [N-1:0] sd, input logic clr);
        exp_t e;
        exp_t g;
        logic n_ack;
        logic sh;
        logic ld;
        int   lp;

        reset = rst; start = st; stop = sp; dir = d; step_req = req;
        seed_valid = sv; seed = sd; clr_err = clr;

        n_ack = 1'b0; sh = 1'b0; ld = 1'b0; lp = -1;
        if (rst) begin
            m_st = M_IDLE; m_phase = 0; m_wraps = 0; m_err = 1'b0;
        end else begin
            if (clr) m_err = 1'b0;
            case (m_st)
                M_IDLE:  if (sv) ld = 1'b1; else if (st) m_st = M_RUN;
                M_RUN:   if (sp) m_st = M_HOLD; else sh = 1'b1;
                M_HOLD: begin
                    if (sv) ld = 1'b1;
                    else if (sp) m_st = M_IDLE;
                    else if (st) m_st = M_RUN;
                    else if (req && !m_ack) begin sh = 1'b1; n_ack = 1'b1; end
                end
                default: m_st = M_IDLE;
            endcase
            if (sh) begin
                if (!d) begin
                    if (m_phase == 2*N - 1) begin m_phase = 0; m_wraps = (m_wraps + 1) % 256; end
                    else m_phase = m_phase + 1;
                end else begin
                    if (m_phase == 0) begin m_phase = 2*N - 1; m_wraps = (m_wraps + 1) % 256; end
                    else m_phase = m_phase - 1;
                end
            end
            if (ld) begin
                for (int p = 0; p < 2*N; p++) if (pat(p) == sd) lp = p;
                if (lp >= 0) m_phase = lp;
                else begin m_phase = 0; m_err = 1'b1; m_st = M_FAULT; end
            end
        end
        m_ack = n_ack;

        e.name  = name;
        e.q     = pat(m_phase);
        e.phase = PW'(m_phase);
        e.wraps = WRAPW'(m_wraps);
        e.busy  = (m_st == M_RUN);
        e.err   = m_err;
        e.ack   = m_ack;
        sb.push_back(e);

        @(posedge clk);
        @(negedge clk);

        if (sb.size() == 0) begin
            chk({name, ".sb_empty"}, 32'd1, 32'd0);
        end else begin
            g = sb.pop_front();
            chk({g.name, ".q"},     32'(q),        32'(g.q));
            chk({g.name, ".phase"}, 32'(phase),    32'(g.phase));
            chk({g.name, ".wraps"}, 32'(wraps),    32'(g.wraps));
            chk({g.name, ".busy"},  32'(busy),     32'(g.busy));
            chk({g.name, ".err"},   32'(err),      32'(g.err));
            chk({g.name, ".ack"},   32'(step_ack), 32'(g.ack));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; dir = 1'b0; step_req = 1'b0;
        seed_valid = 1'b0; seed = '0; clr_err = 1'b0;
        @(negedge clk);

        // T1: reset then idle
        cyc("t1_rst", 1, 0, 0, 0, 0, 0, '0, 0);
        repeat (3) cyc("t1_idle", 0, 0, 0, 0, 0, 0, '0, 0);
        chk("t1_q", 32'(q), 32'd0);
        chk("t1_busy", 32'(busy), 32'd0);

        // T2: start, full forward lap
        cyc("t2_start", 0, 1, 0, 0, 0, 0, '0, 0);
        chk("t2_start_q", 32'(q), 32'd0);
        for (int i = 0; i < 12; i++) cyc("t2_run", 0, 0, 0, 0, 0, 0, '0, 0);
        chk("t2_wraps", 32'(wraps), 32'd1);
        chk("t2_q", 32'(q), 32'(6'b000000));

        // T3: stop at 111000, two step handshakes
        for (int i = 0; i < 3; i++) cyc("t3_run", 0, 0, 0, 0, 0, 0, '0, 0);
        chk("t3_q_before_stop", 32'(q), 32'(6'b111000));
        cyc("t3_stop", 0, 0, 1, 0, 0, 0, '0, 0);
        cyc("t3_step1", 0, 0, 0, 0, 1, 0, '0, 0);
        chk("t3_q_step1", 32'(q), 32'(6'b111100));
        cyc("t3_gap", 0, 0, 0, 0, 1, 0, '0, 0);
        cyc("t3_step2", 0, 0, 0, 0, 1, 0, '0, 0);
        cyc("t3_drop", 0, 0, 0, 0, 0, 0, '0, 0);
        chk("t3_q_step2", 32'(q), 32'(6'b111110));
        cyc("t3_to_idle", 0, 1, 1, 0, 0, 0, '0, 0);

        // T4: legal seed, illegal seed, FAULT, clr_err
        cyc("t4_seed_ok", 0, 1, 0, 0, 0, 1, 6'b110000, 0);
        chk("t4_phase", 32'(phase), 32'd2);
        cyc("t4_seed_bad", 0, 0, 0, 0, 0, 1, 6'b101000, 0);
        chk("t4_err", 32'(err), 32'd1);
        cyc("t4_fault", 0, 1, 0, 0, 0, 0, '0, 0);
        cyc("t4_idle", 0, 0, 0, 0, 0, 0, '0, 0);
        cyc("t4_clr_vs_bad", 0, 0, 0, 0, 0, 1, 6'b010000, 1);
        cyc("t4_fault2", 0, 0, 0, 0, 0, 0, '0, 0);
        cyc("t4_clr", 0, 0, 0, 0, 0, 0, '0, 1);
        chk("t4_err_clr", 32'(err), 32'd0);

        // T5: reverse wrap then forward wrap, seed ignored in RUN, random dir
        cyc("t5_start", 0, 1, 0, 0, 0, 0, '0, 0);
        cyc("t5_rev", 0, 0, 0, 1, 0, 0, '0, 0);
        chk("t5_rev_q", 32'(q), 32'(6'b000001));
        chk("t5_rev_phase", 32'(phase), 32'd11);
        cyc("t5_fwd", 0, 0, 0, 0, 0, 0, '0, 0);
        chk("t5_fwd_wraps", 32'(wraps), 32'd3);
        cyc("t5_seed_in_run", 0, 0, 0, 0, 0, 1, 6'b101000, 0);
        for (int i = 0; i < 24; i++)
            cyc("t5_rand", 0, 0, 0, 1'($urandom_range(0, 1)), 0, 0, '0, 0);
        cyc("t5_stop", 0, 0, 1, 0, 0, 0, '0, 0);

        // HOLD seed loads, then T6: reset in RUN at phase 7 with step_req high
        cyc("t6_hseed_rev", 0, 0, 0, 0, 0, 1, 6'b000111, 0);
        chk("t6_hseed_phase", 32'(phase), 32'd9);
        cyc("t6_hseed_full", 0, 0, 0, 0, 0, 1, 6'b111111, 0);
        cyc("t6_start", 0, 1, 0, 0, 0, 0, '0, 0);
        cyc("t6_run", 0, 0, 0, 0, 1, 0, '0, 0);
        chk("t6_phase7", 32'(phase), 32'd7);
        cyc("t6_rst", 1, 0, 0, 0, 1, 0, '0, 0);
        cyc("t6_after", 0, 0, 0, 0, 1, 0, '0, 0);
        chk("t6_ack", 32'(step_ack), 32'd0);

        // Reset mid-handshake in HOLD discards the pending ack
        cyc("t6_go", 0, 1, 0, 0, 0, 0, '0, 0);
        cyc("t6_halt", 0, 0, 1, 0, 0, 0, '0, 0);
        cyc("t6_hreq", 0, 0, 0, 1, 1, 0, '0, 0);
        cyc("t6_hrst", 1, 0, 0, 0, 1, 0, '0, 0);
        cyc("t6_hidle", 0, 0, 0, 0, 0, 0, '0, 0);

        if (sb.size() != 0) chk("sb_leftover", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
